// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes bitstream words MSB-first onto ccff_head
// and repacks the bits leaving the chain on ccff_tail into readback words.
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              ccff_head,
    output logic              chain_shift,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] cap;
    logic [WORD_W-1:0] capn;
    logic [WW-1:0]     wcnt;
    logic [BW-1:0]     bcnt;
    logic              last_bit;
    logic              word_end;

    assign capn     = {cap[WORD_W-2:0], ccff_tail};
    assign last_bit = (bcnt == BW'(CHAIN_LEN - 1));
    assign word_end = (wcnt == WW'(WORD_W - 1)) || last_bit;

    // A new word is only taken once the readback register is (or is being) emptied.
    assign wr_ready    = (state == LOAD) && (!rd_valid || rd_ready);
    assign chain_shift = (state == SHIFT);
    assign ccff_head   = chain_shift & sreg[WORD_W-1];
    assign busy        = (state == LOAD) || (state == SHIFT);
    assign done        = (state == DONE);

    always_ff @(posedge CK) begin
        if (!RN) begin
            state    <= IDLE;
            sreg     <= '0;
            cap      <= '0;
            wcnt     <= '0;
            bcnt     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (rd_valid && rd_ready)
                rd_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bcnt  <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (wr_valid && wr_ready) begin
                        sreg  <= wr_data;
                        wcnt  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    cap  <= capn;
                    wcnt <= wcnt + 1'b1;
                    bcnt <= bcnt + 1'b1;
                    if (word_end) begin
                        // Left-align a short final word; unused low bits read as zero.
                        rd_data  <= capn << (WW'(WORD_W - 1) - wcnt);
                        rd_valid <= 1'b1;
                        state    <= last_bit ? DONE : LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a 16-bit and a 12-bit chain driven in lockstep, each with
// its own chain model; head streams and readback words checked against the spec.
module tb_ccff_loader;
    logic            CK, RN, start, wr_valid, rd_ready;
    logic [7:0]      wr_data;
    logic [1:0]      wr_ready, ccff_head, chain_shift, ccff_tail, rd_valid, busy, done;
    logic [1:0][7:0] rd_data;

    logic [15:0] chain [2];
    logic        preload;

    logic [15:0] hstream [2] = '{16'h0, 16'h0};
    int          strobes [2] = '{0, 0};
    int          nrd     [2] = '{0, 0};
    logic [7:0]  rdw     [2][128];

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [7:0] w0, w1;
        logic [7:0] r16_0, r16_1, r12_0, r12_1;
    } vec_t;
    vec_t tbl [4];

    ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) u16 (
        .CK(CK), .RN(RN), .start(start), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready[0]), .ccff_head(ccff_head[0]), .chain_shift(chain_shift[0]),
        .ccff_tail(ccff_tail[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .rd_ready(rd_ready), .busy(busy[0]), .done(done[0]));

    ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) u12 (
        .CK(CK), .RN(RN), .start(start), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready[1]), .ccff_head(ccff_head[1]), .chain_shift(chain_shift[1]),
        .ccff_tail(ccff_tail[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .rd_ready(rd_ready), .busy(busy[1]), .done(done[1]));

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Chain model: bit [len-1] is the tail, so the chain value reads in emission order.
    assign ccff_tail[0] = chain[0][15];
    assign ccff_tail[1] = chain[1][11];

    always @(posedge CK) begin
        if (preload) begin
            chain[0] <= 16'hF00F;
            chain[1] <= 16'h0F00;
        end else begin
            for (int i = 0; i < 2; i++)
                if (chain_shift[i] === 1'b1)
                    chain[i] <= {chain[i][14:0], ccff_head[i]};
        end
    end

    always @(negedge CK) begin
        for (int i = 0; i < 2; i++) begin
            if (chain_shift[i] === 1'b1) begin
                hstream[i] <= {hstream[i][14:0], ccff_head[i]};
                strobes[i] <= strobes[i] + 1;
            end
            if (rd_valid[i] === 1'b1 && rd_ready === 1'b1) begin
                if (nrd[i] < 128)
                    rdw[i][nrd[i]] <= rd_data[i];
                nrd[i] <= nrd[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Readback words predicted from what the chain model currently holds.
    task automatic predict(output logic [7:0] e00, e01, e10, e11);
        logic [15:0] p1;
        p1  = {chain[1][11:0], 4'h0};
        e00 = chain[0][15:8];
        e01 = chain[0][7:0];
        e10 = p1[15:8];
        e11 = p1[7:0];
    endtask

    // mode: 0 plain, 1 random handshakes, 2 read back-pressure, 3 stray start in SHIFT
    task automatic do_pass(input logic [7:0] w0, w1, e00, e01, e10, e11, input int mode);
        logic [15:0] full, act_h, exp_h;
        int          sb [2];
        int          rb [2];
        int          t, cl;
        bit          ok;
        full = {w0, w1};
        for (int i = 0; i < 2; i++) begin
            sb[i] = strobes[i];
            rb[i] = nrd[i];
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_data = (k == 0) ? w0 : w1;
            if (mode == 1) begin
                wr_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            wr_valid = 1'b1;
            if (mode == 2 && k == 1) begin
                rd_ready = 1'b0;
                t = 0;
                while (rd_valid !== 2'b11 && t < 50) begin
                    tick();
                    t++;
                end
                ok = (t < 50);
                repeat (6) begin
                    if (wr_ready !== 2'b00 || chain_shift !== 2'b00 || rd_valid !== 2'b11)
                        ok = 1'b0;
                    tick();
                end
                check("bp_hold", k, 32'(ok), 32'd1);
                rd_ready = 1'b1;
            end
            t = 0;
            forever begin
                if (mode == 1)
                    rd_ready = 1'($urandom_range(0, 1));
                #1;
                if (wr_ready === 2'b11 || t >= 100)
                    break;
                tick();
                t++;
            end
            check("wr_accept", k, 32'(t < 100), 32'd1);
            tick();
            wr_valid = 1'b0;
            if (mode == 3 && k == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        t = 0;
        while (done !== 2'b11 && t < 200) begin
            if (mode == 1)
                rd_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        check("done", 0, 32'(t < 200), 32'd1);
        rd_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            cl    = (i == 0) ? 16 : 12;
            act_h = 16'(hstream[i] << (16 - cl));
            exp_h = 16'((full >> (16 - cl)) << (16 - cl));
            check("strobes", i, 32'(strobes[i] - sb[i]), 32'(cl));
            check("head", i, 32'(act_h), 32'(exp_h));
            check("rd_count", i, 32'(nrd[i] - rb[i]), 32'd2);
            check("rd0", i, 32'(rdw[i][rb[i]]), 32'((i == 0) ? e00 : e10));
            check("rd1", i, 32'(rdw[i][rb[i] + 1]), 32'((i == 0) ? e01 : e11));
        end
    endtask

    task automatic check_idle(input string nm);
        for (int i = 0; i < 2; i++)
            check(nm, i, {18'd0, wr_ready[i], ccff_head[i], chain_shift[i], rd_valid[i],
                          busy[i], done[i], rd_data[i]}, 32'd0);
    endtask

    initial begin
        logic [7:0] e00, e01, e10, e11;
        int t;
        tbl[0] = '{w0: 8'hA5, w1: 8'h3C, r16_0: 8'hF0, r16_1: 8'h0F, r12_0: 8'hF0, r12_1: 8'h00};
        tbl[1] = '{w0: 8'h00, w1: 8'h00, r16_0: 8'hA5, r16_1: 8'h3C, r12_0: 8'hA5, r12_1: 8'h30};
        tbl[2] = '{w0: 8'hFF, w1: 8'hB7, r16_0: 8'h00, r16_1: 8'h00, r12_0: 8'h00, r12_1: 8'h00};
        tbl[3] = '{w0: 8'h12, w1: 8'h34, r16_0: 8'hFF, r16_1: 8'hB7, r12_0: 8'hFF, r12_1: 8'hB0};

        RN = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b1;
        preload = 1'b1;
        repeat (3) tick();
        preload = 1'b0;
        check_idle("reset");
        RN = 1'b1;
        tick();

        for (int v = 0; v < 4; v++)
            do_pass(tbl[v].w0, tbl[v].w1, tbl[v].r16_0, tbl[v].r16_1,
                    tbl[v].r12_0, tbl[v].r12_1, 0);

        predict(e00, e01, e10, e11);
        do_pass(8'hC3, 8'h5A, e00, e01, e10, e11, 2);
        predict(e00, e01, e10, e11);
        do_pass(8'h69, 8'hE1, e00, e01, e10, e11, 3);

        // Reset partway through the first word, then a clean reload.
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_data  = 8'h96;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        t = strobes[0];
        while (strobes[0] - t < 3 && strobes[0] - t < 20) tick();
        check("pre_reset_shift", 0, 32'(strobes[0] - t), 32'd3);
        RN = 1'b0;
        tick();
        RN = 1'b1;
        check_idle("mid_reset");
        tick();
        predict(e00, e01, e10, e11);
        do_pass(8'h0F, 8'hF0, e00, e01, e10, e11, 0);

        for (int r = 0; r < 6; r++) begin
            predict(e00, e01, e10, e11);
            do_pass(8'($urandom), 8'($urandom), e00, e01, e10, e11, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
